msrv32_ifetch: RTL and testbench
================================

# msrv32_ifetch

Instruction-fetch stage sitting directly downstream of the PC-select block. It owns the architectural fetch PC register, which feeds the PC block's `pc_in`, and loads it from the PC block's `pc_mux_out` output. It drives the AHB-Lite instruction bus in pipelined fashion and buffers returned words in a small FIFO. It presents instructions to decode with a valid/ready handshake and flushes on branch, trap or return redirects.

## Interface
- `BOOT_ADDRESS`, default 32'h0000_0000: fetch PC after reset.
- `FIFO_DEPTH`, default 2: instruction buffer entries; power of two, at least 2.
- `clk_in`  in  1  clock; all state on rising edge.
- `rst_in`  in  1  synchronous, active-high reset.
- `next_pc_in`  in  32  next PC from the PC-select block (`pc_mux_out`).
- `redirect_in`  in  1  branch taken, trap or mret; `next_pc_in` is the new target.
- `misaligned_instr_in`  in  1  target misaligned; valid only with `redirect_in`.
- `pc_out`  out  32  current fetch PC; feeds the PC block's `pc_in`.
- `haddr_out`  out  32  AHB address; equals `pc_out`.
- `htrans_out`  out  2  2'b00 IDLE, 2'b10 NONSEQ.
- `hrdata_in`  in  32  AHB read data.
- `hready_in`  in  1  AHB transfer-done / address-accept.
- `hresp_in`  in  1  AHB error, sampled with `hready_in`.
- `instr_out`  out  32  FIFO head instruction.
- `instr_pc_out`  out  32  PC of the head instruction.
- `instr_valid_out`  out  1  head valid.
- `instr_ready_in`  in  1  decode accepts the head.
- `instr_fault_out`  out  1  head is a bus-error entry.
- `instr_misaligned_out`  out  1  head is a misaligned-target entry.

## Operation
**Handshake events**
- push = data phase completes, no discard; pop = `instr_valid_out` and `instr_ready_in`.
- accept = `htrans_out`=NONSEQ and `hready_in`=1.

**States:** BOOT, RUN, HALT_ERR, HALT_MIS.
- Reset:
  - state BOOT; `pc_out`=`BOOT_ADDRESS`; `htrans_out`=IDLE.
  - FIFO empty; no outstanding data phase; discard flag clear.
  - All instr outputs 0.
- BOOT goes to RUN unconditionally on the next clock.

**RUN**
- Issue rule: `htrans_out`=NONSEQ iff count + outstanding − pop < `FIFO_DEPTH`; otherwise IDLE. `haddr_out`=`pc_out` always.
- On accept:
  - set outstanding;
  - record `pc_out` as the data-phase PC;
  - `pc_out` ← `next_pc_in`.
- Data phase with `hready_in`=1: clear outstanding. Unless discarding, push {`hrdata_in`, data-phase PC, fault=`hresp_in`}.
- Pushed fault entry: state ← HALT_ERR; issue stops.
- Data phase with `hready_in`=0: wait; no new address may be accepted.

**Redirect** (`redirect_in`=1, any state except BOOT)
- FIFO cleared in the same clock; a push in that clock is dropped.
- Any outstanding data phase, and any address accepted in that clock, is marked discard. Its data is dropped on completion.
- `pc_out` ← `next_pc_in`.
- Next state: HALT_MIS if `misaligned_instr_in`, else RUN.
- A pop in the same clock is ignored, because the FIFO is cleared.

**HALT_ERR**
- No issue.
- Waits for the fault entry to be popped, then remains halted until a redirect.

**HALT_MIS**
- No issue.
- Presents a synthetic head: valid=1, `instr_out`=32'h0000_0013, `instr_pc_out`=`pc_out`, `instr_misaligned_out`=1.
- Persists until a redirect.

**FIFO and widths**
- Write and read pointers are log2(`FIFO_DEPTH`) bits and wrap modulo the depth.
- count is log2(`FIFO_DEPTH`)+1 bits.
- Simultaneous push and pop on a full FIFO is legal; count is unchanged.
- Overflow is impossible by the issue rule. A push into a full FIFO is a design error; verification asserts it never occurs.

## Timing
- Reset release at edge 0:
  - cycle 1: NONSEQ to `BOOT_ADDRESS`;
  - with `hready_in`=1, data sampled at the end of cycle 2;
  - `instr_valid_out`=1 in cycle 3.
- Fetch latency: 2 cycles from accept to head valid when the FIFO is empty.
- Throughput: 1 instruction per clock with `hready_in`=1 and `instr_ready_in`=1.
- Redirect in cycle N:
  - NONSEQ to the target in cycle N+1;
  - `instr_valid_out`=0 in cycle N+1;
  - target instruction valid in cycle N+3 at the earliest.
- FIFO outputs are registered from storage; no combinational path from `hrdata_in` to `instr_out`.
- `pc_out` changes only on accept, redirect or reset.

## Test plan
- Reset, `hready_in`=1, memory word = address, `instr_ready_in`=1:
  - `haddr_out` steps 0, 4, 8, …;
  - instr_out 0, 4, 8 on consecutive cycles starting cycle 3.
- `instr_ready_in`=0 for 6 cycles:
  - exactly `FIFO_DEPTH` entries buffered, then `htrans_out`=IDLE;
  - on release, instructions drain in order with no loss or duplication.
- `hready_in`=0 for 3 cycles during the data phase of 0x8:
  - `pc_out` holds 0xC;
  - no new accept;
  - 0x8 is delivered once `hready_in` returns.
- `redirect_in` with `next_pc_in`=0x100 while the data phase for 0x10 is outstanding:
  - 0x10 is never delivered;
  - next head `instr_pc_out`=0x100;
  - NONSEQ to 0x100 in the following cycle.
- `hresp_in`=1 on the fetch of 0x20:
  - head `instr_fault_out`=1 with PC 0x20;
  - no further NONSEQ until a redirect to 0x40 resumes fetching.
- `redirect_in` with `misaligned_instr_in`=1 and target 0x202:
  - head valid with `instr_misaligned_out`=1, PC 0x202, `instr_out`=0x13;
  - `htrans_out` stays IDLE.

Source files
------------

// File: rtl/msrv32_ifetch_if.sv
// Instruction-fetch port bundle: PC-select link, AHB-Lite instruction bus and
// the decode-side valid/ready handshake.
interface msrv32_ifetch_if;
  // PC-select block
  logic [31:0] next_pc_in;
  logic        redirect_in;
  logic        misaligned_instr_in;
  logic [31:0] pc_out;

  // AHB-Lite instruction bus
  logic [31:0] haddr_out;
  logic [1:0]  htrans_out;
  logic [31:0] hrdata_in;
  logic        hready_in;
  logic        hresp_in;

  // Decode handshake
  logic [31:0] instr_out;
  logic [31:0] instr_pc_out;
  logic        instr_valid_out;
  logic        instr_ready_in;
  logic        instr_fault_out;
  logic        instr_misaligned_out;

  // Fetch stage side
  modport master (
    input  next_pc_in,
    input  redirect_in,
    input  misaligned_instr_in,
    output pc_out,
    output haddr_out,
    output htrans_out,
    input  hrdata_in,
    input  hready_in,
    input  hresp_in,
    output instr_out,
    output instr_pc_out,
    output instr_valid_out,
    input  instr_ready_in,
    output instr_fault_out,
    output instr_misaligned_out
  );

  // Environment side: PC block, bus slave and decode
  modport slave (
    output next_pc_in,
    output redirect_in,
    output misaligned_instr_in,
    input  pc_out,
    input  haddr_out,
    input  htrans_out,
    output hrdata_in,
    output hready_in,
    output hresp_in,
    input  instr_out,
    input  instr_pc_out,
    input  instr_valid_out,
    output instr_ready_in,
    input  instr_fault_out,
    input  instr_misaligned_out
  );
endinterface

// File: rtl/msrv32_ifetch.sv
// Instruction-fetch stage: owns the fetch PC, issues pipelined AHB-Lite reads,
// buffers returned words in a small FIFO and flushes on redirects.
module msrv32_ifetch #(
  parameter logic [31:0] BOOT_ADDRESS = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH   = 2
) (
  input logic             clk_in,
  input logic             rst_in,
  msrv32_ifetch_if.master bus
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam logic [AW+1:0] DEPTH_LIMIT   = (AW+2)'(FIFO_DEPTH);
  localparam logic [1:0]    HTRANS_IDLE   = 2'b00;
  localparam logic [1:0]    HTRANS_NONSEQ = 2'b10;
  localparam logic [31:0]   NOP_INSTR     = 32'h0000_0013;

  typedef enum logic [1:0] {
    BOOT,
    RUN,
    HALT_ERR,
    HALT_MIS
  } state_t;

  state_t        state;
  state_t        state_nxt;

  logic [31:0]   pc;
  logic [31:0]   dp_pc;
  logic          outstanding;
  logic          discard;

  logic [31:0]   mem_instr [FIFO_DEPTH];
  logic [31:0]   mem_pc    [FIFO_DEPTH];
  logic          mem_fault [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;

  logic          fifo_valid;
  logic          pop;
  logic          issue;
  logic          accept;
  logic          complete;
  logic          redirect;
  logic          push;
  logic [AW+1:0] occupancy;

  // Bus and FIFO handshake events for this clock
  always_comb begin
    fifo_valid = (count != '0);
    pop        = fifo_valid && bus.instr_ready_in;
    complete   = outstanding && bus.hready_in;
    redirect   = bus.redirect_in && (state != BOOT);
    push       = complete && !discard && !redirect;
    // Slots that would be committed after this clock if another address went out
    occupancy  = {1'b0, count} + {{(AW+1){1'b0}}, outstanding}
                 - {{(AW+1){1'b0}}, pop};
  end

  // Next-state and issue decision
  always_comb begin
    state_nxt = state;
    issue     = 1'b0;
    unique case (state)
      BOOT:     state_nxt = RUN;
      RUN: begin
        issue = (occupancy < DEPTH_LIMIT);
        if (push && bus.hresp_in) state_nxt = HALT_ERR;
      end
      HALT_ERR: state_nxt = HALT_ERR;
      HALT_MIS: state_nxt = HALT_MIS;
      default:  state_nxt = BOOT;
    endcase
    if (redirect) state_nxt = bus.misaligned_instr_in ? HALT_MIS : RUN;
    accept = issue && bus.hready_in;
  end

  // State register
  always_ff @(posedge clk_in) begin
    if (rst_in) state <= BOOT;
    else        state <= state_nxt;
  end

  // Fetch PC and data-phase tracking
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      pc          <= BOOT_ADDRESS;
      dp_pc       <= '0;
      outstanding <= 1'b0;
      discard     <= 1'b0;
    end else begin
      if (accept || redirect) pc <= bus.next_pc_in;
      if (accept) dp_pc <= pc;
      // hready ends the current data phase and opens the next one if an
      // address was accepted; a phase opened under redirect is dead on arrival.
      // A stalled phase caught by a redirect keeps its discard mark.
      if (bus.hready_in) begin
        outstanding <= accept;
        discard     <= accept && redirect;
      end else begin
        discard     <= discard || (redirect && outstanding);
      end
    end
  end

  // FIFO storage; contents are only observed through count-gated outputs
  always_ff @(posedge clk_in) begin
    if (push) begin
      mem_instr[wr_ptr] <= bus.hrdata_in;
      mem_pc[wr_ptr]    <= dp_pc;
      mem_fault[wr_ptr] <= bus.hresp_in;
    end
  end

  // FIFO pointers and occupancy; a redirect empties the buffer outright
  always_ff @(posedge clk_in) begin
    if (rst_in || redirect) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
    end
  end

  // Bus-side outputs
  always_comb begin
    bus.pc_out     = pc;
    bus.haddr_out  = pc;
    bus.htrans_out = issue ? HTRANS_NONSEQ : HTRANS_IDLE;
  end

  // Decode-side head: synthetic NOP marker when halted on a misaligned target
  always_comb begin
    bus.instr_out            = '0;
    bus.instr_pc_out         = '0;
    bus.instr_valid_out      = 1'b0;
    bus.instr_fault_out      = 1'b0;
    bus.instr_misaligned_out = 1'b0;
    if (state == HALT_MIS) begin
      bus.instr_out            = NOP_INSTR;
      bus.instr_pc_out         = pc;
      bus.instr_valid_out      = 1'b1;
      bus.instr_misaligned_out = 1'b1;
    end else if (fifo_valid) begin
      bus.instr_out       = mem_instr[rd_ptr];
      bus.instr_pc_out    = mem_pc[rd_ptr];
      bus.instr_valid_out = 1'b1;
      bus.instr_fault_out = mem_fault[rd_ptr];
    end
  end

endmodule

// File: tb/tb_msrv32_ifetch.sv
// Lockstep bench for msrv32_ifetch: a reference fetch model predicts bus
// activity each cycle and a scoreboard queue holds expected FIFO entries.
module tb_msrv32_ifetch;

  localparam int unsigned  DEPTH = 2;
  localparam logic [31:0]  BOOT  = 32'h0000_0000;

  typedef enum int unsigned {M_BOOT, M_RUN, M_ERR, M_MIS} mstate_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] data;
    logic        fault;
  } entry_t;

  logic clk_in = 1'b0;
  logic rst_in;

  always #5 clk_in = ~clk_in;

  msrv32_ifetch_if bus ();

  msrv32_ifetch #(
    .BOOT_ADDRESS(BOOT),
    .FIFO_DEPTH  (DEPTH)
  ) dut (
    .clk_in(clk_in),
    .rst_in(rst_in),
    .bus   (bus)
  );

  entry_t      sb[$];
  mstate_t     m_state;
  logic [31:0] m_pc;
  logic [31:0] m_dp_pc;
  logic        m_out;
  logic        m_disc;
  logic [31:0] fault_addr;
  logic        first_after_reset;
  int          total = 0;
  int          bad   = 0;

  // Memory contents: distinct from the address so data/PC swaps show up
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp)
    else begin
      bad++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk_in);
    rst_in                  = 1'b1;
    bus.redirect_in         = 1'b0;
    bus.misaligned_instr_in = 1'b0;
    bus.instr_ready_in      = 1'b1;
    bus.hready_in           = 1'b1;
    bus.hresp_in            = 1'b0;
    bus.next_pc_in          = '0;
    bus.hrdata_in           = '0;
    @(posedge clk_in);
    @(posedge clk_in);
    sb.delete();
    m_state           = M_BOOT;
    m_pc              = BOOT;
    m_dp_pc           = '0;
    m_out             = 1'b0;
    m_disc            = 1'b0;
    first_after_reset = 1'b1;
  endtask

  // One clock: drive at negedge, check just after, advance model at posedge
  task automatic tick(input logic rdy, input logic hrdy, input logic redir = 1'b0,
                      input logic [31:0] tgt = 32'h0, input logic mis = 1'b0);
    logic   m_valid, m_pop, m_issue, m_acc, m_cmp, m_push, m_redir;
    entry_t e;
    @(negedge clk_in);
    rst_in                  = 1'b0;
    bus.instr_ready_in      = rdy;
    bus.hready_in           = hrdy;
    bus.redirect_in         = redir;
    bus.misaligned_instr_in = mis;
    bus.next_pc_in          = redir ? tgt : m_pc + 32'd4;
    bus.hrdata_in           = m_out ? mem_word(m_dp_pc) : 32'hBAD0_BAD0;
    bus.hresp_in            = m_out && (m_dp_pc == fault_addr);
    #1;
    m_valid = (m_state == M_MIS) || (sb.size() != 0);
    m_pop   = (m_state != M_MIS) && (sb.size() != 0) && rdy;
    m_issue = (m_state == M_RUN) &&
              ((sb.size() + int'(m_out) - int'(m_pop)) < int'(DEPTH));

    check("htrans", 32'(bus.htrans_out), m_issue ? 32'h2 : 32'h0);
    check("haddr", bus.haddr_out, m_pc);
    check("pc", bus.pc_out, m_pc);
    check("valid", 32'(bus.instr_valid_out), 32'(m_valid));
    if (first_after_reset) begin
      check("rst_instr", bus.instr_out, 32'h0);
      check("rst_instr_pc", bus.instr_pc_out, 32'h0);
      check("rst_fault", 32'(bus.instr_fault_out), 32'h0);
      check("rst_mis", 32'(bus.instr_misaligned_out), 32'h0);
      first_after_reset = 1'b0;
    end
    if (m_state == M_MIS) begin
      check("mis_instr", bus.instr_out, 32'h0000_0013);
      check("mis_pc", bus.instr_pc_out, m_pc);
      check("mis_flag", 32'(bus.instr_misaligned_out), 32'h1);
      check("mis_fault", 32'(bus.instr_fault_out), 32'h0);
    end else if (sb.size() != 0) begin
      check("head_instr", bus.instr_out, sb[0].data);
      check("head_pc", bus.instr_pc_out, sb[0].pc);
      check("head_fault", 32'(bus.instr_fault_out), 32'(sb[0].fault));
      check("head_mis", 32'(bus.instr_misaligned_out), 32'h0);
    end

    @(posedge clk_in);
    m_acc   = m_issue && hrdy;
    m_cmp   = m_out && hrdy;
    m_redir = redir && (m_state != M_BOOT);
    m_push  = m_cmp && !m_disc && !m_redir;
    if (m_pop) void'(sb.pop_front());
    if (m_push) begin
      total++;
      assert (sb.size() < int'(DEPTH))
      else begin
        bad++;
        $error("FAIL overflow: observed %0d entries expected below %0d", sb.size(), DEPTH);
      end
      e.pc    = m_dp_pc;
      e.data  = mem_word(m_dp_pc);
      e.fault = (m_dp_pc == fault_addr);
      sb.push_back(e);
    end
    if (m_state == M_BOOT)          m_state = M_RUN;
    else if (m_redir)               m_state = mis ? M_MIS : M_RUN;
    else if (m_push && e.fault)     m_state = M_ERR;
    if (m_redir) sb.delete();
    if (m_acc) begin
      m_dp_pc = m_pc;
      m_disc  = m_redir;
    end else if (m_out && !hrdy && m_redir) begin
      m_disc  = 1'b1;
    end
    if (m_acc)      m_out = 1'b1;
    else if (m_cmp) m_out = 1'b0;
    if (m_acc || m_redir) m_pc = redir ? tgt : m_pc + 32'd4;
  endtask

  initial begin
    fault_addr = 32'hFFFF_FFFF;

    // Streaming from reset, then decode back-pressure and release
    do_reset();
    repeat (10) tick(1'b1, 1'b1);
    repeat (6)  tick(1'b0, 1'b1);
    repeat (8)  tick(1'b1, 1'b1);

    // Data phase of 0x8 stretched for three cycles
    do_reset();
    repeat (4) tick(1'b1, 1'b1);
    repeat (3) tick(1'b1, 1'b0);
    repeat (6) tick(1'b1, 1'b1);

    // Redirect to 0x100 while the 0x10 data phase is stalled
    do_reset();
    repeat (6) tick(1'b1, 1'b1);
    tick(1'b1, 1'b0, 1'b1, 32'h0000_0100);
    repeat (6) tick(1'b1, 1'b1);

    // Bus error on 0x20, halted fetch, resume via redirect to 0x40
    do_reset();
    fault_addr = 32'h0000_0020;
    repeat (14) tick(1'b1, 1'b1);
    tick(1'b1, 1'b1, 1'b1, 32'h0000_0040);
    fault_addr = 32'hFFFF_FFFF;
    repeat (6) tick(1'b1, 1'b1);

    // Misaligned redirect to 0x202 with the bus busy, then recover at 0x300
    do_reset();
    repeat (4) tick(1'b1, 1'b1);
    tick(1'b0, 1'b1, 1'b1, 32'h0000_0202, 1'b1);
    repeat (3) tick(1'b1, 1'b1);
    repeat (2) tick(1'b0, 1'b1);
    tick(1'b1, 1'b1, 1'b1, 32'h0000_0300);
    repeat (6) tick(1'b1, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
